// File: rtl/fifo_entry_ctrl_pkg.sv
// Shared types and helpers for the in-order entry controller.
package fifo_ctrl_pkg;

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_e;

  // Pointer increment with an explicit wrap, so DEPTH need not be a power of two.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_entry_ctrl_if.sv
// Handshake bundle between the entry controller and its allocator/retire clients.
interface fifo_entry_ctrl_if #(
  parameter int DEPTH = 6,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
);
  logic             alloc_req;
  logic             alloc_ready;
  logic [IDX_W-1:0] alloc_idx;
  logic [DEPTH-1:0] alloc_onehot;
  logic             done_valid;
  logic [IDX_W-1:0] done_idx;
  logic             retire_en;
  logic             retire_fire;
  logic [IDX_W-1:0] retire_idx;
  logic             flush;
  logic             drain_req;
  logic             drained;
  logic [DEPTH-1:0] valid_entry;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;

  modport master (
    output alloc_req, done_valid, done_idx, retire_en, flush, drain_req,
    input  alloc_ready, alloc_idx, alloc_onehot, retire_fire, retire_idx,
           drained, valid_entry, count, full, empty
  );

  modport slave (
    input  alloc_req, done_valid, done_idx, retire_en, flush, drain_req,
    output alloc_ready, alloc_idx, alloc_onehot, retire_fire, retire_idx,
           drained, valid_entry, count, full, empty
  );
endinterface

// File: rtl/fifo_entry_ctrl_ptr_wrap.sv
// Registered circular pointer: increment-and-wrap with a synchronous clear.
module fifo_ptr_wrap
  import fifo_ctrl_pkg::*;
#(
  parameter int DEPTH = 6,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [IDX_W-1:0] ptr_o
);
  logic [IDX_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i)      ptr_d = '0;
    else if (inc_i) ptr_d = IDX_W'(wrap_inc(32'(ptr_q), DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;
endmodule

// File: rtl/fifo_entry_ctrl.sv
// Allocate / complete / retire controller for a DEPTH-entry circular in-order buffer,
// with flush and drain support for pipeline recovery.
module fifo_entry_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DEPTH = 6,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input logic               clk,
  input logic               rst_n,
  fifo_entry_ctrl_if.slave  bus
);
  logic [IDX_W-1:0] head_ptr, tail_ptr;
  logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d;
  logic [DEPTH-1:0] head_oh, tail_oh, done_oh;
  logic [CNT_W-1:0] count_q, count_d;
  state_e           state_q, state_d;
  logic             drained_q, drained_d;
  logic             full, alloc_ready, alloc_fire, retire_fire, done_hit;

  assign head_oh = DEPTH'(1) << head_ptr;
  assign tail_oh = DEPTH'(1) << tail_ptr;
  // Out-of-range indices shift clean out of the mask, so they never hit.
  assign done_oh = DEPTH'(1) << bus.done_idx;

  assign full        = (count_q == CNT_W'(DEPTH));
  assign alloc_ready = rst_n && !full && (state_q == RUN) && !bus.flush;
  assign alloc_fire  = bus.alloc_req && alloc_ready;
  assign retire_fire = rst_n && bus.retire_en && !bus.flush && |(valid_q & done_q & head_oh);
  assign done_hit    = bus.done_valid && !bus.flush && |(done_oh & valid_q)
                       && !(alloc_fire && (done_oh == tail_oh))
                       && !(retire_fire && (done_oh == head_oh));

  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    count_d = count_q;
    if (done_hit) done_d = done_d | done_oh;
    if (retire_fire) begin
      valid_d = valid_d & ~head_oh;
      done_d  = done_d & ~head_oh;
    end
    if (alloc_fire) begin
      valid_d = valid_d | tail_oh;
      done_d  = done_d & ~tail_oh;
    end
    case ({alloc_fire, retire_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (bus.flush) begin
      valid_d = '0;
      done_d  = '0;
      count_d = '0;
    end
  end

  always_comb begin
    state_d   = state_q;
    drained_d = 1'b0;
    case (state_q)
      RUN:   if (bus.drain_req) state_d = DRAIN;
      DRAIN: if (count_q == '0) begin
        state_d   = RUN;
        drained_d = 1'b1;
      end
      default: state_d = RUN;
    endcase
    if (bus.flush) begin
      state_d   = RUN;
      drained_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= '0;
      done_q    <= '0;
      count_q   <= '0;
      state_q   <= RUN;
      drained_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      done_q    <= done_d;
      count_q   <= count_d;
      state_q   <= state_d;
      drained_q <= drained_d;
    end
  end

  fifo_ptr_wrap #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_head (
    .clk(clk), .rst_n(rst_n), .clr_i(bus.flush), .inc_i(retire_fire), .ptr_o(head_ptr)
  );

  fifo_ptr_wrap #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_tail (
    .clk(clk), .rst_n(rst_n), .clr_i(bus.flush), .inc_i(alloc_fire), .ptr_o(tail_ptr)
  );

  assign bus.alloc_ready  = alloc_ready;
  assign bus.alloc_idx    = tail_ptr;
  assign bus.alloc_onehot = tail_oh;
  assign bus.retire_fire  = retire_fire;
  assign bus.retire_idx   = head_ptr;
  assign bus.drained      = drained_q;
  assign bus.valid_entry  = valid_q;
  assign bus.count        = count_q;
  assign bus.full         = full;
  assign bus.empty        = (count_q == '0);
endmodule

// File: tb/tb_fifo_entry_ctrl.sv
// Bench for fifo_entry_ctrl: directed scenarios plus random traffic against a queue model.
module tb_fifo_entry_ctrl;
  localparam int DEPTH = 6;
  localparam int IDX_W = 3;
  localparam int CNT_W = 3;
  localparam int VW    = 1 + IDX_W + DEPTH + 1 + IDX_W + 1 + DEPTH + CNT_W + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   inv_on = 1'b0;

  fifo_entry_ctrl_if #(.DEPTH(DEPTH)) bus();

  fifo_entry_ctrl #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  logic [VW-1:0] obs_vec;
  assign obs_vec = {bus.alloc_ready, bus.alloc_idx, bus.alloc_onehot, bus.retire_fire,
                    bus.retire_idx, bus.drained, bus.valid_entry, bus.count, bus.full, bus.empty};

  // Reference model: the buffer is an ordered queue of live indices.
  int mq[$];
  bit mdone [DEPTH];
  int mtail   = 0;
  bit mdrain  = 1'b0;
  bit mdrained = 1'b0;

  function automatic logic [VW-1:0] exp_vec();
    logic [DEPTH-1:0] vm;
    bit rdy, rf;
    int h;
    vm = '0;
    h  = (mq.size() > 0) ? mq[0] : mtail;
    foreach (mq[k]) vm[mq[k]] = 1'b1;
    rdy = rst_n && (mq.size() < DEPTH) && !mdrain && !bus.flush;
    rf  = rst_n && bus.retire_en && (mq.size() > 0) && mdone[h] && !bus.flush;
    return {rdy, IDX_W'(mtail), DEPTH'(1) << mtail, rf, IDX_W'(h), mdrained, vm,
            CNT_W'(mq.size()), (mq.size() == DEPTH), (mq.size() == 0)};
  endfunction

  task automatic mupd();
    int ds, h, di;
    bit af, rf, inq, dok;
    if (!rst_n || bus.flush) begin
      mq.delete();
      foreach (mdone[k]) mdone[k] = 1'b0;
      mtail = 0; mdrain = 1'b0; mdrained = 1'b0;
      return;
    end
    ds  = mq.size();
    h   = (ds > 0) ? mq[0] : mtail;
    di  = int'(bus.done_idx);
    af  = bus.alloc_req && (ds < DEPTH) && !mdrain;
    rf  = bus.retire_en && (ds > 0) && mdone[h];
    inq = 1'b0;
    foreach (mq[k]) if (mq[k] == di) inq = 1'b1;
    dok = bus.done_valid && inq && !(af && di == mtail) && !(rf && di == h);
    if (dok) mdone[di] = 1'b1;
    if (rf) begin mdone[h] = 1'b0; void'(mq.pop_front()); end
    if (af) begin mdone[mtail] = 1'b0; mq.push_back(mtail); mtail = (mtail + 1) % DEPTH; end
    mdrained = 1'b0;
    if (!mdrain) begin
      if (bus.drain_req) mdrain = 1'b1;
    end else if (ds == 0) begin
      mdrain = 1'b0; mdrained = 1'b1;
    end
  endtask

  task automatic drv(input bit a, input bit dv, input int di, input bit re,
                     input bit fl, input bit dr, input bit rs = 1'b1);
    @(negedge clk);
    rst_n = rs;
    bus.alloc_req = a; bus.done_valid = dv; bus.done_idx = IDX_W'(di);
    bus.retire_en = re; bus.flush = fl; bus.drain_req = dr;
    #1;
  endtask

  task automatic adv();
    @(posedge clk);
    mupd();
  endtask

  // Structural invariants: occupancy matches popcount and valid is one run from head.
  always begin
    logic [DEPTH-1:0] m;
    @(negedge clk); #3;
    if (inv_on && rst_n) begin
      m = '0;
      for (int k = 0; k < int'(bus.count); k++) m[(int'(bus.retire_idx) + k) % DEPTH] = 1'b1;
      checks++;
      if ($countones(bus.valid_entry) != int'(bus.count) || m !== bus.valid_entry) begin
        errors++;
        $display("FAIL invariant valid=%b count=%0d head=%0d want run %b",
                 bus.valid_entry, bus.count, bus.retire_idx, m);
      end
    end
  end

  task automatic test_reset();
    drv(1, 1, 3, 1, 0, 1, 0);
    checks++;
    if (bus.alloc_ready !== 1'b0 || bus.retire_fire !== 1'b0) begin
      errors++; $display("FAIL reset_ready got rdy=%b rf=%b want 0 0", bus.alloc_ready, bus.retire_fire);
    end
    adv();
    drv(0, 0, 0, 0, 0, 0, 0); adv();
    drv(0, 0, 0, 0, 0, 0);
    checks++;
    if ({bus.count, bus.empty, bus.full, bus.drained, bus.alloc_idx, bus.retire_idx, bus.valid_entry}
        !== {3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 6'd0}) begin
      errors++; $display("FAIL reset_state got count=%0d empty=%b full=%b drained=%b valid=%b",
                         bus.count, bus.empty, bus.full, bus.drained, bus.valid_entry);
    end
    checks++;
    if (obs_vec !== exp_vec()) begin
      errors++; $display("FAIL reset_vec got %h want %h", obs_vec, exp_vec());
    end
    adv();
    inv_on = 1'b1;
  endtask

  task automatic test_fill_wrap();
    for (int i = 0; i < DEPTH; i++) begin
      drv(1, 0, 0, 0, 0, 0);
      checks++;
      if (bus.alloc_ready !== 1'b1 || int'(bus.alloc_idx) != i || bus.alloc_onehot !== 6'(1 << i)) begin
        errors++; $display("FAIL fill_idx got rdy=%b idx=%0d oh=%b want 1 %0d", bus.alloc_ready,
                           bus.alloc_idx, bus.alloc_onehot, i);
      end
      adv();
    end
    drv(1, 1, 0, 0, 0, 0);
    checks++;
    if ({bus.full, bus.alloc_ready, bus.count} !== {1'b1, 1'b0, 3'd6}) begin
      errors++; $display("FAIL fill_full got full=%b rdy=%b count=%0d want 1 0 6",
                         bus.full, bus.alloc_ready, bus.count);
    end
    adv();
    drv(1, 0, 0, 1, 0, 0);
    checks++;
    if ({bus.retire_fire, bus.retire_idx, bus.alloc_ready} !== {1'b1, 3'd0, 1'b0}) begin
      errors++; $display("FAIL wrap_retire got rf=%b idx=%0d rdy=%b want 1 0 0",
                         bus.retire_fire, bus.retire_idx, bus.alloc_ready);
    end
    adv();
    drv(1, 0, 0, 0, 0, 0);
    checks++;
    if ({bus.count, bus.alloc_ready, bus.alloc_idx, bus.retire_idx} !== {3'd5, 1'b1, 3'd0, 3'd1}) begin
      errors++; $display("FAIL wrap_alloc got count=%0d rdy=%b idx=%0d head=%0d want 5 1 0 1",
                         bus.count, bus.alloc_ready, bus.alloc_idx, bus.retire_idx);
    end
    adv();
    drv(0, 0, 0, 0, 1, 0); adv();
  endtask

  task automatic test_inorder();
    for (int i = 0; i < 4; i++) begin drv(1, 0, 0, 0, 0, 0); adv(); end
    drv(0, 1, 2, 0, 0, 0); adv();
    drv(0, 1, 3, 1, 0, 0);
    checks++;
    if (bus.retire_fire !== 1'b0) begin
      errors++; $display("FAIL inorder_hold got rf=%b want 0", bus.retire_fire);
    end
    adv();
    drv(0, 1, 0, 1, 0, 0);
    checks++;
    if (bus.retire_fire !== 1'b0) begin
      errors++; $display("FAIL inorder_nobypass got rf=%b want 0", bus.retire_fire);
    end
    adv();
    drv(0, 1, 1, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) drv(0, 0, 0, 1, 0, 0);
      checks++;
      if (bus.retire_fire !== 1'b1 || int'(bus.retire_idx) != k) begin
        errors++; $display("FAIL inorder_seq got rf=%b idx=%0d want 1 %0d", bus.retire_fire, bus.retire_idx, k);
      end
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++; $display("FAIL inorder_vec got %h want %h", obs_vec, exp_vec());
      end
      adv();
    end
  endtask

  task automatic test_done_on_alloc();
    drv(1, 1, 4, 0, 0, 0);
    checks++;
    if (bus.alloc_idx !== 3'd4) begin
      errors++; $display("FAIL donealloc_idx got %0d want 4", bus.alloc_idx);
    end
    adv();
    for (int k = 0; k < 3; k++) begin
      drv(0, 0, 0, 1, 0, 0);
      checks++;
      if (bus.retire_fire !== 1'b0 || bus.count !== 3'd1) begin
        errors++; $display("FAIL donealloc_ignored got rf=%b count=%0d want 0 1", bus.retire_fire, bus.count);
      end
      adv();
    end
    drv(0, 0, 0, 0, 1, 0); adv();
  endtask

  task automatic test_drain();
    int pulses = 0;
    for (int i = 0; i < 3; i++) begin drv(1, 0, 0, 0, 0, 0); adv(); end
    for (int i = 0; i < 3; i++) begin drv(0, 1, i, 0, 0, 0); adv(); end
    drv(0, 0, 0, 0, 0, 1); adv();
    drv(1, 0, 0, 0, 0, 0);
    checks++;
    if (bus.alloc_ready !== 1'b0 || bus.count !== 3'd3) begin
      errors++; $display("FAIL drain_block got rdy=%b count=%0d want 0 3", bus.alloc_ready, bus.count);
    end
    adv();
    for (int c = 0; c < 8; c++) begin
      drv(0, 0, 0, 1, 0, 0);
      if (bus.drained === 1'b1) pulses++;
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++; $display("FAIL drain_vec cyc %0d got %h want %h", c, obs_vec, exp_vec());
      end
      adv();
    end
    drv(0, 0, 0, 0, 0, 0);
    checks++;
    if (pulses != 1 || bus.alloc_ready !== 1'b1 || bus.count !== 3'd0) begin
      errors++; $display("FAIL drain_done got pulses=%0d rdy=%b count=%0d want 1 1 0",
                         pulses, bus.alloc_ready, bus.count);
    end
    adv();
    drv(0, 0, 0, 0, 0, 1); adv();
    drv(0, 0, 0, 0, 0, 0);
    checks++;
    if ({bus.drained, bus.alloc_ready} !== 2'b00) begin
      errors++; $display("FAIL drain_empty1 got drained=%b rdy=%b want 0 0", bus.drained, bus.alloc_ready);
    end
    adv();
    drv(0, 0, 0, 0, 0, 0);
    checks++;
    if ({bus.drained, bus.alloc_ready} !== 2'b11) begin
      errors++; $display("FAIL drain_empty2 got drained=%b rdy=%b want 1 1", bus.drained, bus.alloc_ready);
    end
    adv();
    drv(0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.drained !== 1'b0) begin
      errors++; $display("FAIL drain_empty3 got drained=%b want 0", bus.drained);
    end
    adv();
  endtask

  task automatic test_flush_wrap();
    drv(0, 0, 0, 0, 1, 0); adv();
    for (int i = 0; i < 4; i++) begin drv(1, 0, 0, 0, 0, 0); adv(); end
    for (int i = 0; i < 4; i++) begin drv(0, 1, i, 0, 0, 0); adv(); end
    for (int i = 0; i < 4; i++) begin drv(0, 0, 0, 1, 0, 0); adv(); end
    for (int i = 0; i < 3; i++) begin drv(1, 0, 0, 0, 0, 0); adv(); end
    drv(0, 1, 4, 0, 0, 0); adv();
    drv(1, 0, 0, 1, 1, 0);
    checks++;
    if ({bus.retire_idx, bus.alloc_idx, bus.count, bus.retire_fire, bus.alloc_ready}
        !== {3'd4, 3'd1, 3'd3, 1'b0, 1'b0}) begin
      errors++; $display("FAIL flush_pre got head=%0d tail=%0d count=%0d rf=%b rdy=%b want 4 1 3 0 0",
                         bus.retire_idx, bus.alloc_idx, bus.count, bus.retire_fire, bus.alloc_ready);
    end
    adv();
    drv(0, 0, 0, 1, 0, 0);
    checks++;
    if ({bus.count, bus.empty, bus.retire_idx, bus.alloc_idx, bus.retire_fire, bus.valid_entry}
        !== {3'd0, 1'b1, 3'd0, 3'd0, 1'b0, 6'd0}) begin
      errors++; $display("FAIL flush_post got count=%0d empty=%b head=%0d tail=%0d rf=%b",
                         bus.count, bus.empty, bus.retire_idx, bus.alloc_idx, bus.retire_fire);
    end
    adv();
    for (int i = 0; i < 2; i++) begin drv(1, 0, 0, 0, 0, 0); adv(); end
    drv(0, 0, 0, 0, 0, 1); adv();
    drv(0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.alloc_ready !== 1'b0) begin
      errors++; $display("FAIL rstdrain_in got rdy=%b want 0", bus.alloc_ready);
    end
    adv();
    drv(0, 0, 0, 0, 0, 0, 0); adv();
    drv(1, 0, 0, 0, 0, 0);
    checks++;
    if ({bus.count, bus.empty, bus.alloc_ready, bus.drained, bus.retire_idx, bus.alloc_idx}
        !== {3'd0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0}) begin
      errors++; $display("FAIL rstdrain_out got count=%0d empty=%b rdy=%b drained=%b",
                         bus.count, bus.empty, bus.alloc_ready, bus.drained);
    end
    adv();
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      int di;
      if ($urandom_range(7) == 0 || mq.size() == 0) di = int'($urandom_range(7));
      else di = mq[$urandom_range(mq.size() - 1)];
      drv($urandom_range(3) != 0, $urandom_range(1) == 1, di, $urandom_range(3) != 0,
          $urandom_range(63) == 0, $urandom_range(31) == 0);
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++; $display("FAIL random_vec cyc %0d got %h want %h", c, obs_vec, exp_vec());
      end
      adv();
    end
  endtask

  initial begin
    bus.alloc_req = 0; bus.done_valid = 0; bus.done_idx = '0;
    bus.retire_en = 0; bus.flush = 0; bus.drain_req = 0;
    test_reset();
    test_fill_wrap();
    test_inorder();
    test_done_on_alloc();
    test_drain();
    test_flush_wrap();
    test_random();
    inv_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fifo_entry_ctrl.md
Name: fifo_entry_ctrl

Overview:
Allocation, completion and retirement controller for a DEPTH-entry circular in-order buffer, such as a ROB or load/store queue.
- Keeps the per-entry valid and done bitmaps plus the head and tail pointers.
- Hands out the next free slot to the allocator and retires entries at the head in order once they are marked done.
- Provides a flush and a drain mode for pipeline recovery.

Parameters:
DEPTH, 6, number of buffer entries (≥2; need not be a power of two)
IDX_W, $clog2(DEPTH), entry index width
CNT_W, $clog2(DEPTH+1), occupancy count width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
alloc_req  in  1  allocator requests one entry this cycle
alloc_ready  out  1  entry available; alloc fires when alloc_req && alloc_ready
alloc_idx  out  IDX_W  index granted (current tail)
alloc_onehot  out  DEPTH  one-hot of alloc_idx
done_valid  in  1  mark an entry complete
done_idx  in  IDX_W  entry to mark complete
retire_en  in  1  downstream permits retirement this cycle
retire_fire  out  1  head entry retires this cycle
retire_idx  out  IDX_W  current head index
flush  in  1  discard all entries
drain_req  in  1  pulse: stop allocating until empty
drained  out  1  one-cycle pulse when drain completes
valid_entry  out  DEPTH  registered valid bitmap
count  out  CNT_W  registered occupancy
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- Reset (rst_n=0 at clk edge):
  - head=0, tail=0, valid=0, done=0, count=0, state=RUN.
  - drained=0, full=0, empty=1.
  - alloc_ready deasserts from the same edge; retire_fire=0.
- Pointer arithmetic:
  - Pointers wrap from DEPTH-1 to 0 by explicit compare, not modulo-2^IDX_W.
  - count = number of set valid bits, maintained incrementally (+1 on alloc, -1 on retire, net 0 when both occur).
- alloc_ready = !full && state==RUN && !flush. The same cycle's retire is not bypassed; a full buffer refuses allocation even if it retires.
- alloc_idx = tail (combinational from registers); alloc_onehot = 1<<tail.
- On alloc fire: valid[tail]<=1, done[tail]<=0, tail<=tail+1 (wrapped). Visible next cycle.
- done_valid:
  - Sets done[done_idx] next cycle, only if valid[done_idx]=1.
  - Ignored if the entry is invalid or done_idx ≥ DEPTH.
  - A done targeting the entry being allocated or retired in the same cycle is ignored.
- retire_fire = retire_en && valid[head] && done[head] && !flush. Purely combinational from registers, so a done is never bypassed into a retire in the same cycle.
- On retire fire: valid[head]<=0, done[head]<=0, head<=head+1 (wrapped). At most one retire per cycle.
- flush:
  - Highest priority below reset; suppresses alloc, done and retire that cycle.
  - Next cycle: valid=0, done=0, head=tail=0, count=0, state=RUN, drained=0.
- State machine, RUN / DRAIN:
  - RUN -> DRAIN on drain_req (no flush).
  - In DRAIN, alloc_ready=0 while retirement continues normally.
  - DRAIN -> RUN when count==0 at a clock edge; drained=1 for exactly that next cycle.
  - drain_req while already empty: enter DRAIN, then next cycle return to RUN and pulse drained.
  - drain_req while in DRAIN is ignored.
  - flush in DRAIN returns to RUN with no drained pulse.
- Wrap-around: head>tail is legal. full and empty are both derived from count, so head==tail is never ambiguous.
- Assertions (bench):
  - count == popcount(valid).
  - The valid bitmap is always one contiguous run from head, wrapping.
  - done is a subset of valid.

Decomposition:
- Shared package fifo_ctrl_pkg:
  - state enum {RUN, DRAIN}.
  - Wrap-increment function, parameterised by DEPTH.
- One natural sub-module: fifo_ptr_wrap, the registered pointer with increment-and-wrap and a sync clear. Instantiate it twice, for head and tail.

Test Plan:
1. Reset, then 6 allocs back-to-back (DEPTH=6) -> alloc_idx 0..5, full=1 after the 6th, alloc_ready=0, count=6.
2. With full, done idx 0 then retire_en=1 -> retire_fire next cycle, retire_idx=0, count=5; next alloc gets idx 0, confirming wrap.
3. Alloc 0..3, done on 2 and 3 only, retire_en=1 -> no retire (head 0 not done); done 0, 1 -> four retires in consecutive cycles, indices 0,1,2,3.
4. Allocate in the same cycle as done_idx=tail -> done ignored; entry stays not-done, and no retire occurs when it becomes head.
5. count=3, drain_req -> alloc_ready=0; after the 3 entries retire, drained pulses once and alloc_ready returns to 1. A drain_req while empty pulses drained 2 cycles later.
6. Mid-wrap (head=4, tail=1, count=3), flush concurrent with alloc_req and retire -> next cycle count=0, head=tail=0, empty=1, no retire_fire. An rst_n=0 in the middle of DRAIN gives the same result with state=RUN.
